// File: rtl/if_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package if_prefetch_buf_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_prefetch_buf_inst_fifo.sv
// DEPTH x {pc, inst} FIFO with synchronous flush and an occupancy count.
// Storage is not reset; only the pointers and count are.
module if_prefetch_buf_inst_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Entry storage: written on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch stage: sequential fetch from a combinational ROM into a
// small FIFO, valid/ready hand-off to decode, redirect flushes the buffer.
// Optional build macro IF_PERF_CNT_EN adds the stall_cnt_o performance counter.
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_data_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [31:0]              id_inst_o,
  output logic [31:0]              id_pc_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]              stall_cnt_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       fetch_pc_p0;
  logic              ce_p0;
  fetch_entry_t      head_p1;
  logic [CNT_W-1:0]  count_p1;
  logic              vld_p1;
  logic              pop_p1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // FSM next state: one boot cycle, then fetch until the next reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_FETCH;
    endcase
  end

  // Stage p0: fetch gating; redirect suppresses both push and hand-off.
  always_comb begin
    ce_p0  = 1'b0;
    vld_p1 = 1'b0;
    pop_p1 = 1'b0;
    if (!rst && !redirect_i) begin
      ce_p0  = (state == S_FETCH) && (count_p1 < FULL_CNT);
      vld_p1 = (count_p1 != '0);
      pop_p1 = vld_p1 && id_ready_i;
    end
  end

  // Fetch address: reset, redirect, then sequential advance on each read.
  always_ff @(posedge clk) begin
    if (rst)             fetch_pc_p0 <= RESET_PC;
    else if (redirect_i) fetch_pc_p0 <= word_align(redirect_pc_i);
    else if (ce_p0)      fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
  end

  // Stage p0 -> p1 boundary: the ROM word is captured with its pc.
  if_prefetch_buf_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .push       (ce_p0),
    .push_entry ('{pc: fetch_pc_p0, inst: rom_data_i}),
    .pop        (pop_p1),
    .head       (head_p1),
    .count      (count_p1)
  );

  // Output drive: everything reads zero while reset is held.
  always_comb begin
    rom_ce_o   = ce_p0;
    id_valid_o = vld_p1;
    rom_addr_o = 32'h0;
    id_inst_o  = 32'h0;
    id_pc_o    = 32'h0;
    count_o    = '0;
    if (!rst) begin
      rom_addr_o = fetch_pc_p0;
      id_inst_o  = head_p1.inst;
      id_pc_o    = head_p1.pc;
      count_o    = count_p1;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating count of cycles where decode is ready but nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'h0;
    end else if ((state == S_FETCH) && id_ready_i && !vld_p1 &&
                 (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf (DEPTH=4, RESET_PC=0).
module tb_if_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  count;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr ^ 32'hA5A5_0000;

  if_prefetch_buf #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_inst_o     (id_inst),
    .id_pc_o       (id_pc),
`ifdef IF_PERF_CNT_EN
    .stall_cnt_o   (stall_cnt),
`endif
    .count_o       (count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two reset cycles, then release; returns in the boot cycle.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    id_ready = rdy;
    step(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_ready = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL rst_ce got %0h want 0", rom_ce); end
      n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", id_valid); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
      n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", rom_addr); end
    end
    rst = 1'b0;
    #1;
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL boot_ce got %0h want 0", rom_ce); end
    n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL boot_addr got %h want 0", rom_addr); end
    step(1);
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL first_ce got %0h want 1", rom_ce); end
    n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got %h want 0", rom_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset(1'b1);
    step(2);
    for (int k = 0; k < 8; k++) begin
      epc = 32'(k) * 32'd4;
      n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h want 1", k, id_valid); end
      n_vec++; if (id_pc !== epc) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", k, id_pc, epc); end
      n_vec++; if (id_inst !== (epc ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", k, id_inst, epc ^ 32'hA5A5_0000); end
      n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
      step(1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] epc;
    do_reset(1'b0);
    step(5);
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", count); end
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL bp_ce got %0h want 0", rom_ce); end
    n_vec++; if (rom_addr !== 32'h10) begin n_err++; $display("FAIL bp_addr got %h want 10", rom_addr); end
    step(2);
    n_vec++; if (rom_addr !== 32'h10) begin n_err++; $display("FAIL bp_addr_hold got %h want 10", rom_addr); end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count_hold got %0d want 4", count); end
    id_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      epc = 32'(k) * 32'd4;
      n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %0h want 1", k, id_valid); end
      n_vec++; if (id_pc !== epc) begin n_err++; $display("FAIL drain_pc[%0d] got %h want %h", k, id_pc, epc); end
      if (k == 0) begin
        n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL drain_ce_full got %0h want 0", rom_ce); end
      end
      if (k == 1) begin
        n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL resume_ce got %0h want 1", rom_ce); end
        n_vec++; if (rom_addr !== 32'h10) begin n_err++; $display("FAIL resume_addr got %h want 10", rom_addr); end
      end
      step(1);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step(4);
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count got %0d want 3", count); end
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %0h want 0", id_valid); end
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL redir_ce got %0h want 0", rom_ce); end
    step(1);
    redirect = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL redir_count got %0d want 0", count); end
    n_vec++; if (rom_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", rom_addr); end
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL redir_ce_next got %0h want 1", rom_ce); end
    step(1);
    n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL redir_head_valid got %0h want 1", id_valid); end
    n_vec++; if (id_pc !== 32'h100) begin n_err++; $display("FAIL redir_head_pc got %h want 100", id_pc); end
    n_vec++; if (id_inst !== 32'hA5A5_0100) begin n_err++; $display("FAIL redir_head_inst got %h want a5a50100", id_inst); end
  endtask

  task automatic test_redirect_ready();
    do_reset(1'b0);
    step(4);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rr_valid got %0h want 0", id_valid); end
    step(1);
    redirect = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rr_count got %0d want 0", count); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty_valid got %0h want 0", id_valid); end
    step(1);
    n_vec++; if (id_pc !== 32'h200) begin n_err++; $display("FAIL rr_head_pc got %h want 200", id_pc); end
    n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL rr_head_valid got %0h want 1", id_valid); end
    step(1);
    n_vec++; if (id_pc !== 32'h204) begin n_err++; $display("FAIL rr_next_pc got %h want 204", id_pc); end
    id_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    do_reset(1'b0);
    step(5);
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL rf_pre_count got %0d want 4", count); end
    rst = 1'b1;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rf_rst_count got %0d want 0", count); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rf_rst_valid got %0h want 0", id_valid); end
    step(1);
    rst = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rf_count got %0d want 0", count); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid got %0h want 0", id_valid); end
    n_vec++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL rf_boot_ce got %0h want 0", rom_ce); end
    step(1);
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL rf_fetch_ce got %0h want 1", rom_ce); end
    n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL rf_fetch_addr got %h want 0", rom_addr); end
    step(1);
    n_vec++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rf_head_pc got %h want 0", id_pc); end
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL rf_head_count got %0d want 1", count); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    step(2);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step(1);
    redirect = 1'b0;
    #1;
    n_vec++; if (rom_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", rom_addr); end
    n_vec++; if (rom_ce !== 1'b1) begin n_err++; $display("FAIL wrap_ce got %0h want 1", rom_ce); end
    step(1);
    n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next_addr got %h want 0", rom_addr); end
    n_vec++; if (id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head_pc got %h want fffffffc", id_pc); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    do_reset(1'b1);
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_reset got %0d want 0", stall_cnt); end
    step(2);
    n_vec++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL perf_first got %0d want 1", stall_cnt); end
    for (int k = 0; k < 10; k++) begin
      redirect = ((k % 2) == 0);
      redirect_pc = 32'h40;
      step(1);
    end
    redirect = 1'b0;
    #1;
    n_vec++; if (stall_cnt !== 32'd11) begin n_err++; $display("FAIL perf_redir got %0d want 11", stall_cnt); end
    step(1);
    n_vec++; if (stall_cnt !== 32'd11) begin n_err++; $display("FAIL perf_quiet got %0d want 11", stall_cnt); end
    rst = 1'b1;
    step(1);
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_clear got %0d want 0", stall_cnt); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_ready();
    test_reset_full();
    test_wrap();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
